// File: rtl/alu_exec_stage_if.sv
// Valid/ready bundle between the ALU control unit, the execute stage and its consumer.
// The stage takes the slave side; the producer/consumer pair drives the master side.
interface alu_exec_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALU_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, ALU_ctrl, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow
  );

  modport slave (
    input  in_valid, ALU_ctrl, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: computes result/zero/overflow on acceptance and
// holds up to two results in a main + skid pair so in_ready can be registered.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  alu_exec_stage_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic             lt;
  entry_t           new_entry;

  logic in_fire;
  logic out_fire;

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = (state_q != EMPTY) && bus.out_ready;

  always_comb begin
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    ovf_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1]  != bus.a[WIDTH-1]);
    ovf_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
    // Sign of the difference corrected by overflow gives a true signed a < b.
    lt      = diff[WIDTH-1] ^ ovf_sub;

    new_entry = '0;
    case (bus.ALU_ctrl)
      3'b000: begin
        new_entry.result   = sum;
        new_entry.overflow = ovf_add;
      end
      3'b001: begin
        new_entry.result   = diff;
        new_entry.overflow = ovf_sub;
      end
      3'b010:  new_entry.result = bus.a & bus.b;
      3'b011:  new_entry.result = bus.a | bus.b;
      3'b100:  new_entry.result = bus.a ^ bus.b;
      3'b101:  new_entry.result = ~(bus.a | bus.b);
      3'b110:  new_entry.result = {{(WIDTH-1){1'b0}}, lt};
      default: new_entry.result = '0;
    endcase
    new_entry.zero = (new_entry.result == '0);
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = new_entry;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = new_entry;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = new_entry;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain of main can happen.
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.result    = main_q.result;
  assign bus.zero      = main_q.zero;
  assign bus.overflow  = main_q.overflow;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: ALU ops, back-pressure, streaming and mid-run reset.
module tb_alu_exec_stage;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_exec_stage_if #(.WIDTH(W)) bus ();

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    bus.in_valid = v;
    bus.ALU_ctrl = op;
    bus.a        = x;
    bus.b        = y;
  endtask

  // One op with out_ready high: visible on the outputs right after the accepting edge.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] er, input logic ez, input logic eo);
    bus.out_ready = 1'b1;
    drive(1'b1, op, x, y);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    check({tag, ".valid"}, {31'b0, bus.out_valid}, 32'd1);
    check({tag, ".result"}, bus.result, er);
    check({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, ez});
    check({tag, ".ovf"}, {31'b0, bus.overflow}, {31'b0, eo});
    $display("op %s ctrl=%b a=%h b=%h -> result=%h zero=%b ovf=%b", tag, op, x, y,
             bus.result, bus.zero, bus.overflow);
  endtask

  // Independent reference using wide signed arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic z, output logic o);
    longint sx;
    longint sy;
    longint s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = 32'h0;
    o  = 1'b0;
    case (op)
      3'b000: begin s = sx + sy; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b001: begin s = sx - sy; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b010: r = x & y;
      3'b011: r = x | y;
      3'b100: r = x ^ y;
      3'b101: r = ~(x | y);
      3'b110: r = (sx < sy) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
    z = (r == 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    logic [31:0] er;
    logic        ez;
    logic        eo;

    errors = 0;
    checks = 0;

    // Reset with junk on the inputs: must be discarded.
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h11, 32'h22);
    tick();
    tick();
    check("rst.valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst.in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst.result", bus.result, 32'h0);
    check("rst.zero", {31'b0, bus.zero}, 32'd0);
    check("rst.ovf", {31'b0, bus.overflow}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    check("rst.discard", {31'b0, bus.out_valid}, 32'd0);

    // Directed ALU vectors.
    do_op("add5_7",    3'b000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0);
    do_op("add_ovf",   3'b000, 32'h7FFFFFFF,   32'd1,          32'h80000000,   1'b0, 1'b1);
    do_op("sub_ovf",   3'b001, 32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b0, 1'b1);
    do_op("sub_zero",  3'b001, 32'h1234,       32'h1234,       32'h0,          1'b1, 1'b0);
    do_op("sub_neg",   3'b001, 32'd5,          32'd7,          32'hFFFFFFFE,   1'b0, 1'b0);
    do_op("and",       3'b010, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000,   1'b0, 1'b0);
    do_op("or",        3'b011, 32'hF0F0F0F0,   32'hFF00FF00,   32'hFFF0FFF0,   1'b0, 1'b0);
    do_op("xor",       3'b100, 32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0,   1'b0, 1'b0);
    do_op("nor",       3'b101, 32'h0,          32'h0,          32'hFFFFFFFF,   1'b0, 1'b0);
    do_op("slt_true",  3'b110, 32'h80000000,   32'd1,          32'd1,          1'b0, 1'b0);
    do_op("slt_false", 3'b110, 32'h7FFFFFFF,   32'hFFFFFFFF,   32'd0,          1'b1, 1'b0);
    do_op("reserved",  3'b111, 32'd5,          32'd3,          32'd0,          1'b1, 1'b0);
    tick();
    check("drain.valid", {31'b0, bus.out_valid}, 32'd0);

    // Back-pressure: out_ready low, stream ADD 1+1, 2+2, 3+3.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'd1, 32'd1);
    tick();
    check("bp1.result", bus.result, 32'd2);
    check("bp1.in_ready", {31'b0, bus.in_ready}, 32'd1);
    drive(1'b1, 3'b000, 32'd2, 32'd2);
    tick();
    check("bp2.in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("bp2.result", bus.result, 32'd2);
    drive(1'b1, 3'b000, 32'd3, 32'd3);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp.stall.valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp.stall.result", bus.result, 32'd2);
      check("bp.stall.in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    $display("bp stalled result=%h in_ready=%b", bus.result, bus.in_ready);
    bus.out_ready = 1'b1;
    tick();
    check("bp.out2.result", bus.result, 32'd4);
    check("bp.out2.in_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    check("bp.out3.valid", {31'b0, bus.out_valid}, 32'd1);
    check("bp.out3.result", bus.result, 32'd6);
    tick();
    check("bp.drain.valid", {31'b0, bus.out_valid}, 32'd0);
    check("bp.drain.in_ready", {31'b0, bus.in_ready}, 32'd1);
    $display("bp drained in_ready=%b", bus.in_ready);

    // Full throughput: 16 back-to-back random ops.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 4 == 0) rb = ra;
      model(rop, ra, rb, er, ez, eo);
      drive(1'b1, rop, ra, rb);
      tick();
      check("tp.valid", {31'b0, bus.out_valid}, 32'd1);
      check("tp.result", bus.result, er);
      check("tp.zero", {31'b0, bus.zero}, {31'b0, ez});
      check("tp.ovf", {31'b0, bus.overflow}, {31'b0, eo});
      check("tp.in_ready", {31'b0, bus.in_ready}, 32'd1);
      $display("tp %0d ctrl=%b a=%h b=%h -> result=%h", i, rop, ra, rb, bus.result);
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    check("tp.drain.valid", {31'b0, bus.out_valid}, 32'd0);

    // Mid-operation reset from FULL.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'd10, 32'd0);
    tick();
    drive(1'b1, 3'b000, 32'd20, 32'd0);
    tick();
    check("mr.full.in_ready", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    drive(1'b1, 3'b000, 32'd99, 32'd1);
    tick();
    check("mr.valid", {31'b0, bus.out_valid}, 32'd0);
    check("mr.in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("mr.result", bus.result, 32'h0);
    check("mr.zero", {31'b0, bus.zero}, 32'd0);
    check("mr.ovf", {31'b0, bus.overflow}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mr.nostale", {31'b0, bus.out_valid}, 32'd0);
    end
    $display("mid-reset flushed out_valid=%b", bus.out_valid);
    do_op("post_rst", 3'b000, 32'd30, 32'd4, 32'd34, 1'b0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
